// File: rtl/vdic_dut_2022_pkg.sv
// Shared types and constants for the vdic_dut_2022 bit-serial ALU.
package vdic_dut_2022_pkg;

  localparam int unsigned FRAME_LEN = 11;
  localparam int unsigned MIN_OPS   = 2;
  localparam int unsigned MAX_OPS   = 9;

  typedef enum logic [7:0] {
    CMD_AND = 8'h00,
    CMD_OR  = 8'h01,
    CMD_XOR = 8'h02,
    CMD_ADD = 8'h03
  } cmd_e;

  localparam int unsigned ST_ERR_DATA_COUNT = 0;
  localparam int unsigned ST_ERR_CMD        = 1;
  localparam int unsigned ST_ERR_PARITY     = 2;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_RX_FRAME,
    ST_CALC,
    ST_TX
  } state_e;

  // start, flag, D7..D0, even parity over flag+data
  function automatic logic [FRAME_LEN-1:0] make_frame(input logic flag, input logic [7:0] b);
    return {1'b0, flag, b, ^{flag, b}};
  endfunction

endpackage

// File: rtl/vdic_serial_frame_rx.sv
// Serial frame deserializer; parity checked only when VDIC_DUT_PARITY_CHECK_EN is defined.
module vdic_serial_frame_rx (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       enable_n,
  input  logic       din,
  input  logic       busy,
  output logic       start,
  output logic       frame_done,
  output logic       abort,
  output logic       flag,
  output logic [7:0] data,
  output logic       parity_ok
);
  import vdic_dut_2022_pkg::*;

  localparam logic [3:0] LAST_BIT = 4'(FRAME_LEN - 1);

  logic       active_q, active_d;
  logic [3:0] bit_cnt_q, bit_cnt_d;
  logic       flag_q, flag_d;
  logic [7:0] data_q, data_d;

  // frame_done fires while the parity bit is on din, so the packet FSM
  // consumes the frame on the same edge that samples its parity bit
  always_comb begin
    active_d   = active_q;
    bit_cnt_d  = bit_cnt_q;
    flag_d     = flag_q;
    data_d     = data_q;
    start      = !active_q && !busy && !enable_n && !din;
    abort      = active_q && enable_n;
    frame_done = active_q && !enable_n && (bit_cnt_q == LAST_BIT);
    if (start) begin
      active_d  = 1'b1;
      bit_cnt_d = 4'd1;
    end else if (abort) begin
      active_d = 1'b0;
    end else if (active_q) begin
      if (bit_cnt_q == 4'd1) flag_d = din;
      else if (!frame_done)  data_d = {data_q[6:0], din};
      if (frame_done) active_d  = 1'b0;
      else            bit_cnt_d = bit_cnt_q + 4'd1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      active_q  <= 1'b0;
      bit_cnt_q <= '0;
      flag_q    <= 1'b0;
      data_q    <= '0;
    end else begin
      active_q  <= active_d;
      bit_cnt_q <= bit_cnt_d;
      flag_q    <= flag_d;
      data_q    <= data_d;
    end
  end

  assign flag = flag_q;
  assign data = data_q;
`ifdef VDIC_DUT_PARITY_CHECK_EN
  assign parity_ok = ~^{flag_q, data_q, din};
`else
  assign parity_ok = 1'b1;
`endif

endmodule

// File: rtl/vdic_dut_2022_core.sv
// Bit-serial ALU top: packet FSM, operand accumulators and response transmitter.
// Input parity checking is enabled by defining VDIC_DUT_PARITY_CHECK_EN.
module vdic_dut_2022_core (
  input  logic clk,
  input  logic rst_n,
  input  logic enable_n,
  input  logic din,
  output logic dout,
  output logic dout_valid
);
  import vdic_dut_2022_pkg::*;

  localparam logic [3:0] MIN_N = 4'(MIN_OPS);
  localparam logic [3:0] MAX_N = 4'(MAX_OPS);
  localparam int unsigned TX_W = 3 * FRAME_LEN;

  state_e            state_q, state_d;
  logic [3:0]        op_cnt_q, op_cnt_d;
  logic [7:0]        and_q, and_d, or_q, or_d, xor_q, xor_d;
  logic [15:0]       sum_q, sum_d;
  logic              par_err_q, par_err_d;
  logic [7:0]        cmd_q, cmd_d;
  logic [TX_W-1:0]   tx_sh_q, tx_sh_d;
  logic [5:0]        tx_left_q, tx_left_d;
  logic              dout_q, dout_d, dout_valid_q, dout_valid_d;
  logic [7:0]        status;
  logic [15:0]       result;

  logic       rx_start, rx_done, rx_abort, rx_flag, rx_parity_ok;
  logic [7:0] rx_data;

  vdic_serial_frame_rx u_rx (
    .clk        (clk),
    .rst_n      (rst_n),
    .enable_n   (enable_n),
    .din        (din),
    .busy       ((state_q == ST_CALC) || (state_q == ST_TX)),
    .start      (rx_start),
    .frame_done (rx_done),
    .abort      (rx_abort),
    .flag       (rx_flag),
    .data       (rx_data),
    .parity_ok  (rx_parity_ok)
  );

  always_comb begin
    state_d      = state_q;
    op_cnt_d     = op_cnt_q;
    and_d        = and_q;
    or_d         = or_q;
    xor_d        = xor_q;
    sum_d        = sum_q;
    par_err_d    = par_err_q;
    cmd_d        = cmd_q;
    tx_sh_d      = tx_sh_q;
    tx_left_d    = tx_left_q;
    dout_d       = dout_q;
    dout_valid_d = dout_valid_q;

    status = '0;
    result = '0;
    status[ST_ERR_DATA_COUNT] = (op_cnt_q < MIN_N) || (op_cnt_q > MAX_N);
    status[ST_ERR_PARITY]     = par_err_q;
    case (cmd_q)
      CMD_AND: result = {8'h00, and_q};
      CMD_OR:  result = {8'h00, or_q};
      CMD_XOR: result = {8'h00, xor_q};
      CMD_ADD: result = sum_q;
      default: status[ST_ERR_CMD] = 1'b1;
    endcase

    case (state_q)
      ST_IDLE: if (rx_start) state_d = ST_RX_FRAME;
      ST_RX_FRAME: begin
        if (rx_abort) begin
          state_d   = ST_IDLE;
          op_cnt_d  = '0;
          and_d     = '1;
          or_d      = '0;
          xor_d     = '0;
          sum_d     = '0;
          par_err_d = 1'b0;
        end else if (rx_done) begin
          if (!rx_parity_ok) par_err_d = 1'b1;
          if (rx_flag) begin
            cmd_d   = rx_data;
            state_d = ST_CALC;
          end else begin
            state_d = ST_IDLE;
            // count saturates so oversized packets still flag ERR_DATA_COUNT
            if (op_cnt_q != 4'hF) op_cnt_d = op_cnt_q + 4'd1;
            if (op_cnt_q < MAX_N) begin
              and_d = and_q & rx_data;
              or_d  = or_q | rx_data;
              xor_d = xor_q ^ rx_data;
              sum_d = sum_q + 16'(rx_data);
            end
          end
        end
      end
      ST_CALC: begin
        if (status == 8'h00) begin
          tx_sh_d   = {make_frame(1'b1, status), make_frame(1'b0, result[15:8]),
                       make_frame(1'b0, result[7:0])};
          tx_left_d = 6'(TX_W);
        end else begin
          tx_sh_d   = {make_frame(1'b1, status), 22'b0};
          tx_left_d = 6'(FRAME_LEN);
        end
        op_cnt_d  = '0;
        and_d     = '1;
        or_d      = '0;
        xor_d     = '0;
        sum_d     = '0;
        par_err_d = 1'b0;
        state_d   = ST_TX;
      end
      ST_TX: begin
        if (tx_left_q != 6'd0) begin
          dout_d       = tx_sh_q[TX_W-1];
          dout_valid_d = 1'b1;
          tx_sh_d      = {tx_sh_q[TX_W-2:0], 1'b0};
          tx_left_d    = tx_left_q - 6'd1;
        end else begin
          dout_d       = 1'b0;
          dout_valid_d = 1'b0;
          state_d      = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= ST_IDLE;
      op_cnt_q     <= '0;
      and_q        <= '1;
      or_q         <= '0;
      xor_q        <= '0;
      sum_q        <= '0;
      par_err_q    <= 1'b0;
      cmd_q        <= '0;
      tx_sh_q      <= '0;
      tx_left_q    <= '0;
      dout_q       <= 1'b0;
      dout_valid_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      op_cnt_q     <= op_cnt_d;
      and_q        <= and_d;
      or_q         <= or_d;
      xor_q        <= xor_d;
      sum_q        <= sum_d;
      par_err_q    <= par_err_d;
      cmd_q        <= cmd_d;
      tx_sh_q      <= tx_sh_d;
      tx_left_q    <= tx_left_d;
      dout_q       <= dout_d;
      dout_valid_q <= dout_valid_d;
    end
  end

  assign dout       = dout_q;
  assign dout_valid = dout_valid_q;

endmodule

// File: tb/tb_vdic_dut_2022_core.sv
// Randomized self-checking bench for vdic_dut_2022_core against a packet-level reference model.
module tb_vdic_dut_2022_core;

  logic clk = 1'b0;
  logic rst_n, enable_n, din;
  logic dout, dout_valid;

  int unsigned n_cmp = 0;
  int unsigned n_mis = 0;
  logic [7:0]  ops_q[$];

  always #5 clk = ~clk;

  vdic_dut_2022_core dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .enable_n   (enable_n),
    .din        (din),
    .dout       (dout),
    .dout_valid (dout_valid)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_mis++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [10:0] frm(input logic flag, input logic [7:0] b);
    return {1'b0, flag, b, ^{flag, b}};
  endfunction

  task automatic send_bits(input logic [10:0] f, input int unsigned nbits);
    for (int i = 10; i > 10 - int'(nbits); i--) begin
      din = f[i]; enable_n = 1'b0;
      @(posedge clk); #1;
    end
    din = 1'b1;
  endtask

  task automatic send_frame(input logic flag, input logic [7:0] b, input logic bad);
    logic [10:0] f;
    f = frm(flag, b);
    f[0] = f[0] ^ bad;
    send_bits(f, 11);
  endtask

  task automatic expect_quiet(input string tag, input int unsigned cycles);
    int unsigned seen;
    seen = 0;
    repeat (cycles) begin
      @(negedge clk);
      if (dout_valid) seen++;
    end
    check(tag, seen, 0);
  endtask

  // Sends ops_q plus a command frame and checks latency, length and frames.
  task automatic run_packet(input logic [7:0] cmd, input int bad_idx, input string tag);
    int n, s, len, exp_len;
    logic [7:0]  a, o, x, st;
    logic [15:0] res;
    logic [32:0] got;
    n = ops_q.size(); s = 0; a = 8'hFF; o = 8'h00; x = 8'h00;
    foreach (ops_q[i]) begin
      s += int'(ops_q[i]); a &= ops_q[i]; o |= ops_q[i]; x ^= ops_q[i];
    end
    st = 8'h00;
    st[0] = (n < 2) || (n > 9);
    st[1] = (cmd > 8'd3);
`ifdef VDIC_DUT_PARITY_CHECK_EN
    st[2] = (bad_idx >= 0);
`endif
    case (cmd)
      8'd0:    res = {8'h00, a};
      8'd1:    res = {8'h00, o};
      8'd2:    res = {8'h00, x};
      8'd3:    res = 16'(s);
      default: res = 16'h0000;
    endcase
    exp_len = (st == 8'h00) ? 33 : 11;

    foreach (ops_q[i]) begin
      send_frame(1'b0, ops_q[i], bad_idx == i);
      repeat ($urandom_range(0, 2)) begin @(posedge clk); #1; end
    end
    send_frame(1'b1, cmd, bad_idx == n);

    @(negedge clk); check({tag, ":valid_k0"}, dout_valid, 0);
    @(negedge clk); check({tag, ":valid_k1"}, dout_valid, 0);
    len = 0; got = '0;
    for (int c = 0; c < 40; c++) begin
      @(negedge clk);
      if (!dout_valid) break;
      got = {got[31:0], dout};
      len++;
    end
    check({tag, ":len"}, len, exp_len);
    check({tag, ":dout_idle"}, dout, 0);
    check({tag, ":status"}, got[exp_len-1 -: 11], frm(1'b1, st));
    if (exp_len == 33) begin
      check({tag, ":res_hi"}, got[21:11], frm(1'b0, res[15:8]));
      check({tag, ":res_lo"}, got[10:0],  frm(1'b0, res[7:0]));
    end
  endtask

  initial begin
    rst_n = 1'b0; enable_n = 1'b1; din = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("reset:dout", dout, 0);
    check("reset:dout_valid", dout_valid, 0);
    @(posedge clk); #1;
    rst_n = 1'b1; enable_n = 1'b0;
    @(posedge clk); #1;

    ops_q = '{8'h10, 8'h20, 8'h30};  run_packet(8'h03, -1, "add3");
    ops_q = '{8'hF0, 8'h3C};         run_packet(8'h00, -1, "and2");
    ops_q = {};
    repeat (9) ops_q.push_back(8'hFF);
    run_packet(8'h02, -1, "xor9");
    ops_q = '{8'h55};                run_packet(8'h03, -1, "one_op");
    ops_q = '{8'h12, 8'h34};         run_packet(8'h07, -1, "bad_cmd");
    ops_q = '{8'h10, 8'h20};         run_packet(8'h03, 0, "bad_par");
    ops_q = {};
    repeat (10) ops_q.push_back(8'h01);
    run_packet(8'h01, -1, "ten_ops");

    // reset between operands discards the partial packet
    send_frame(1'b0, 8'h40, 1'b0);
    send_frame(1'b0, 8'h50, 1'b0);
    rst_n = 1'b0;
    repeat (2) begin @(posedge clk); #1; end
    rst_n = 1'b1;
    expect_quiet("rst_mid_pkt:quiet", 20);
    ops_q = '{8'h01, 8'h02};         run_packet(8'h03, -1, "after_rst");

    // reset during a response stops it immediately
    send_frame(1'b0, 8'h05, 1'b0);
    send_frame(1'b0, 8'h06, 1'b0);
    send_frame(1'b1, 8'h03, 1'b0);
    repeat (6) begin @(posedge clk); #1; end
    rst_n = 1'b0;
    @(negedge clk);
    check("rst_mid_tx:valid", dout_valid, 0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    expect_quiet("rst_mid_tx:quiet", 40);

    // enable_n high mid-frame aborts, discarding the earlier operand
    send_frame(1'b0, 8'h77, 1'b0);
    send_bits(frm(1'b0, 8'h99), 5);
    enable_n = 1'b1;
    repeat (2) begin @(posedge clk); #1; end
    enable_n = 1'b0;
    expect_quiet("abort:quiet", 20);
    ops_q = '{8'h01, 8'h02};         run_packet(8'h03, -1, "after_abort");

    for (int t = 0; t < 40; t++) begin
      int unsigned n;
      int bad;
      logic [7:0] cmd;
      n = $urandom_range(1, 11);
      ops_q = {};
      for (int i = 0; i < int'(n); i++) ops_q.push_back(8'($urandom_range(0, 255)));
      cmd = ($urandom_range(0, 5) < 5) ? 8'($urandom_range(0, 3)) : 8'($urandom_range(4, 255));
      bad = ($urandom_range(0, 7) == 0) ? int'($urandom_range(0, n)) : -1;
      run_packet(cmd, bad, $sformatf("rand%0d", t));
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
    $finish;
  end

endmodule
